rf_commit_queue: RTL and testbench
==================================

# rf_commit_queue

In-order commit sequencer placed directly downstream of the bypass register file's write-queue interface. It records each write name when the RF allocates it and collects data-written notifications from up to two writeback ports. It then drives the RF's free port (W_F/WFE) strictly in allocation order, so an entry is committed to the architectural RF only after its data has landed. One instance is paired with each bypass RF and is sized to the RF's name space.

## Interface
- name_width, default 2: width of write names; queue depth = 2**name_width, matching the RF name count.
- addr_width, default 5: architectural register address width, carried for commit tracing.
- CLK  in  1  clock, all state updates on posedge.
- RST  in  1  reset, synchronous, active-high.
- ENQ_E  in  1  allocate: record a name just granted by the RF.
- ENQ_NAME  in  name_width  name granted (the RF's NAME_OUT).
- ENQ_ADDR  in  addr_width  destination register of that name.
- ENQ_READY  out  1  queue not full.
- DONE_E_1 / DONE_E_2  in  1  writeback port 1/2 wrote data for a name.
- DONE_NAME_1 / DONE_NAME_2  in  name_width  name written on port 1/2.
- FREE_E  out  1  head entry is valid and done; request a free.
- FREE_NAME  out  name_width  head name (drives RF W_F).
- FREE_ADDR  out  addr_width  head destination address.
- FREE_READY  in  1  RF accepts the free (the RF's F_READY).
- COUNT  out  name_width+1  occupied entries, 0..2**name_width.
- ERR  out  1  sticky protocol-error flag (see Configuration).

## Operation
- Circular buffer with these fields:
  - head and tail pointers, each name_width bits, wrapping modulo depth;
  - per-slot valid, done and addr.
- Slot index equals name. The RF grants names sequentially, so ENQ_NAME must equal tail.
- Enqueue fires on ENQ_E & ENQ_READY:
  - valid[tail]<=1, done[tail]<=0, addr[tail]<=ENQ_ADDR;
  - tail<=tail+1.
  - ENQ_E while full is dropped with no state change.
- Done on DONE_E_x: sets done[DONE_NAME_x]<=1 only if valid[DONE_NAME_x]; otherwise ignored.
  - Both ports may name different slots in the same cycle; both take effect.
  - Both ports naming the same slot is legal (idempotent).
- Done in the same cycle as the enqueue of that name: the enqueue's done<=0 wins. The writer must not complete a name in its allocation cycle.
- Pop fires on FREE_E & FREE_READY: valid[head]<=0, done[head]<=0, head<=head+1.
- FREE_E = valid[head] & done[head]. Entries are never freed out of order; a completed younger entry waits behind an incomplete head.
- COUNT tracks the occupied-entry count:
  - +1 on enqueue, -1 on pop, unchanged when both or neither occur;
  - full when COUNT==depth, empty when COUNT==0.

## Timing
- Reset values: head=tail=0, all valid=0 and done=0, COUNT=0, ENQ_READY=1, FREE_E=0, FREE_NAME=0, FREE_ADDR=0, ERR=0.
- Reset mid-operation discards all entries. The paired RF is reset in the same cycle.
- ENQ_READY = (COUNT != depth), a function of registered state only. There is no full-bypass: when full and a pop occurs in cycle N, ENQ_READY rises in N+1.
- Done-to-free latency: DONE in cycle N, FREE_E high in cycle N+1 (if that slot is head).
- Pop to next head: a pop in cycle N lets the next entry (if already done) assert FREE_E in N+1. Sustained throughput is one free per cycle.
- FREE_E, once high, holds with stable FREE_NAME/FREE_ADDR until FREE_READY is sampled high.
- Enqueue and pop in the same cycle are legal at every occupancy, including full (pop only, enqueue blocked) and empty (enqueue only, since FREE_E=0).

## Configuration
- COMMIT_QUEUE_CHECK_EN.
- When defined, ERR is set and held until RST by any of:
  - ENQ_E with ENQ_NAME != tail;
  - ENQ_E while full;
  - DONE_E_x naming an invalid slot;
  - DONE_E_x naming the slot being enqueued in the same cycle.
- Without it, ERR is tied to 0 and no checking logic is built. Functional behaviour is identical in both builds.

## Structure
- Shared package holds:
  - the commit entry struct {valid, done, addr};
  - a localparam for depth;
  - a function next_name(name) implementing the modulo-depth increment.
- One sub-module, rf_commit_slot_array: the valid/done/addr storage with one enqueue write port, two done-set ports and one clear port. The pointers, counter and checker stay in the top level.

## Test plan
- Enqueue names 0,1,2 (addr 5,6,7), DONE name 0 -> FREE_E=1, FREE_NAME=0, FREE_ADDR=5 one cycle later; pop with FREE_READY=1 -> COUNT=2.
- Enqueue 0,1, DONE 1 only -> FREE_E stays 0 for 10 cycles. Then DONE 0 -> frees 0 and 1 on consecutive cycles.
- Fill all 4 slots -> ENQ_READY=0 and COUNT=4. ENQ_E held while a pop occurs -> tail does not advance that cycle; ENQ_READY=1 next cycle, and the enqueue of name 0 (wrapped) succeeds.
- FREE_E high with FREE_READY=0 for 3 cycles -> FREE_NAME stable and no pop. FREE_READY=1 -> pops exactly once.
- DONE_E_1 and DONE_E_2 for names 2 and 3 in the same cycle, with heads 0 and 1 done -> four frees on cycles N+1..N+4.
- With COMMIT_QUEUE_CHECK_EN: DONE on an unallocated name 3 -> ERR=1 next cycle and held; RST -> ERR=0 and COUNT=0.

Source files
------------

// File: rtl/rf_commit_queue_pkg.sv
// rf_commit_queue_pkg: shared types and constants for the RF commit queue.
//   NAME_W / ADDR_W : default write-name and register-address widths
//   DEPTH           : queue depth, equal to the RF name count (2**NAME_W)
//   commit_entry_t  : per-slot storage {valid, done, addr}
//   next_name()     : modulo-DEPTH increment of a name / pointer
package rf_commit_queue_pkg;

  localparam int unsigned NAME_W = 2;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 1 << NAME_W;
  localparam int unsigned CNT_W  = NAME_W + 1;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic [ADDR_W-1:0] addr;
  } commit_entry_t;

  // Pointer width equals log2(DEPTH), so natural overflow is the wrap.
  function automatic logic [NAME_W-1:0] next_name(input logic [NAME_W-1:0] name);
    return NAME_W'(name + NAME_W'(1));
  endfunction

endpackage

// File: rtl/rf_commit_queue_if.sv
// rf_commit_queue_if: allocation, writeback-done and free handshake bundle.
//   master : RF/writeback side (drives ENQ_*, DONE_*, FREE_READY)
//   slave  : commit queue (drives ENQ_READY, FREE_*, COUNT, ERR)
interface rf_commit_queue_if
  import rf_commit_queue_pkg::*;
#(
  parameter int unsigned name_width = NAME_W,
  parameter int unsigned addr_width = ADDR_W
);

  logic                  ENQ_E;
  logic [name_width-1:0] ENQ_NAME;
  logic [addr_width-1:0] ENQ_ADDR;
  logic                  ENQ_READY;
  logic                  DONE_E_1;
  logic [name_width-1:0] DONE_NAME_1;
  logic                  DONE_E_2;
  logic [name_width-1:0] DONE_NAME_2;
  logic                  FREE_E;
  logic [name_width-1:0] FREE_NAME;
  logic [addr_width-1:0] FREE_ADDR;
  logic                  FREE_READY;
  logic [name_width:0]   COUNT;
  logic                  ERR;

  modport master (
    output ENQ_E, ENQ_NAME, ENQ_ADDR,
    output DONE_E_1, DONE_NAME_1, DONE_E_2, DONE_NAME_2,
    output FREE_READY,
    input  ENQ_READY, FREE_E, FREE_NAME, FREE_ADDR, COUNT, ERR
  );

  modport slave (
    input  ENQ_E, ENQ_NAME, ENQ_ADDR,
    input  DONE_E_1, DONE_NAME_1, DONE_E_2, DONE_NAME_2,
    input  FREE_READY,
    output ENQ_READY, FREE_E, FREE_NAME, FREE_ADDR, COUNT, ERR
  );

endinterface

// File: rtl/rf_commit_slot_array.sv
// rf_commit_slot_array: per-name valid/done/addr storage.
//   CLK, RST                  : clock, synchronous active-high reset
//   enq_e_i/enq_name_i/addr   : allocate slot (valid=1, done=0, addr)
//   done_e{1,2}_i/name        : mark slot done if it is valid
//   clr_e_i/clr_name_i        : release slot (valid=0, done=0)
//   slot_o                    : registered slot contents
module rf_commit_slot_array
  import rf_commit_queue_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              enq_e_i,
  input  logic [NAME_W-1:0] enq_name_i,
  input  logic [ADDR_W-1:0] enq_addr_i,
  input  logic              done_e1_i,
  input  logic [NAME_W-1:0] done_name1_i,
  input  logic              done_e2_i,
  input  logic [NAME_W-1:0] done_name2_i,
  input  logic              clr_e_i,
  input  logic [NAME_W-1:0] clr_name_i,
  output commit_entry_t     slot_o [DEPTH]
);

  commit_entry_t slot_q [DEPTH];
  commit_entry_t slot_d [DEPTH];

  // Write priority: done-set, then enqueue (its done=0 wins), then clear.
  always_comb begin
    slot_d = slot_q;
    if (done_e1_i && slot_q[done_name1_i].valid) begin
      slot_d[done_name1_i].done = 1'b1;
    end
    if (done_e2_i && slot_q[done_name2_i].valid) begin
      slot_d[done_name2_i].done = 1'b1;
    end
    if (enq_e_i) begin
      slot_d[enq_name_i].valid = 1'b1;
      slot_d[enq_name_i].done  = 1'b0;
      slot_d[enq_name_i].addr  = enq_addr_i;
    end
    if (clr_e_i) begin
      slot_d[clr_name_i].valid = 1'b0;
      slot_d[clr_name_i].done  = 1'b0;
    end
  end

  // Slot storage register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot_o = slot_q;

endmodule

// File: rtl/rf_commit_queue.sv
// rf_commit_queue: in-order commit sequencer behind a bypass RF write queue.
// Records allocated names, collects writeback-done notifications from two
// ports and frees entries to the RF strictly in allocation order.
//   CLK, RST : clock, synchronous active-high reset
//   cq       : slave side of rf_commit_queue_if (ENQ_*, DONE_*, FREE_*,
//              COUNT, ERR)
// Build option: define COMMIT_QUEUE_CHECK_EN to build the sticky protocol
// checker driving ERR; otherwise ERR is tied low.
// name_width/addr_width must match the package NAME_W/ADDR_W.
module rf_commit_queue
  import rf_commit_queue_pkg::*;
#(
  parameter int unsigned name_width = NAME_W,
  parameter int unsigned addr_width = ADDR_W
)(
  input  logic             CLK,
  input  logic             RST,
  rf_commit_queue_if.slave cq
);

  localparam int unsigned CW = name_width + 1;

  logic [name_width-1:0] head_q, head_d;
  logic [name_width-1:0] tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  commit_entry_t         slot [DEPTH];

  logic enq_ready;
  logic enq_fire;
  logic free_e;
  logic pop_fire;

  // Handshakes; FREE_E and ENQ_READY depend on registered state only.
  assign enq_ready = (count_q != CW'(DEPTH));
  assign enq_fire  = cq.ENQ_E & enq_ready;
  assign free_e    = slot[head_q].valid & slot[head_q].done;
  assign pop_fire  = free_e & cq.FREE_READY;

  rf_commit_slot_array u_slots (
    .CLK          (CLK),
    .RST          (RST),
    .enq_e_i      (enq_fire),
    .enq_name_i   (NAME_W'(tail_q)),
    .enq_addr_i   (ADDR_W'(cq.ENQ_ADDR)),
    .done_e1_i    (cq.DONE_E_1),
    .done_name1_i (NAME_W'(cq.DONE_NAME_1)),
    .done_e2_i    (cq.DONE_E_2),
    .done_name2_i (NAME_W'(cq.DONE_NAME_2)),
    .clr_e_i      (pop_fire),
    .clr_name_i   (NAME_W'(head_q)),
    .slot_o       (slot)
  );

  // Pointer and occupancy next state.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq_fire) begin
      tail_d = name_width'(next_name(NAME_W'(tail_q)));
    end
    if (pop_fire) begin
      head_d = name_width'(next_name(NAME_W'(head_q)));
    end
    case ({enq_fire, pop_fire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign cq.ENQ_READY = enq_ready;
  assign cq.FREE_E    = free_e;
  assign cq.FREE_NAME = head_q;
  assign cq.FREE_ADDR = addr_width'(slot[head_q].addr);
  assign cq.COUNT     = count_q;

`ifdef COMMIT_QUEUE_CHECK_EN
  logic err_q, err_d;
  logic proto_err;

  // Protocol violations: out-of-order name, enqueue while full, done on an
  // unallocated slot, done on the slot being allocated this cycle.
  always_comb begin
    proto_err = 1'b0;
    if (cq.ENQ_E && (cq.ENQ_NAME != tail_q)) proto_err = 1'b1;
    if (cq.ENQ_E && !enq_ready)              proto_err = 1'b1;
    if (cq.DONE_E_1 && !slot[cq.DONE_NAME_1].valid) proto_err = 1'b1;
    if (cq.DONE_E_2 && !slot[cq.DONE_NAME_2].valid) proto_err = 1'b1;
    if (cq.DONE_E_1 && enq_fire && (cq.DONE_NAME_1 == tail_q)) proto_err = 1'b1;
    if (cq.DONE_E_2 && enq_fire && (cq.DONE_NAME_2 == tail_q)) proto_err = 1'b1;
    err_d = err_q | proto_err;
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign cq.ERR = err_q;
`else
  // ENQ_NAME is only consumed by the checker; slot index comes from tail.
  logic unused_enq_name;
  assign unused_enq_name = ^cq.ENQ_NAME;
  assign cq.ERR = 1'b0;
`endif

endmodule

// File: tb/tb_rf_commit_queue.sv
// tb_rf_commit_queue: scoreboard bench for rf_commit_queue. Stimulus pushes
// the expected (name, addr) of each allocation; a negedge monitor pops and
// compares on every free handshake. Directed checks cover latency, stall,
// full/wrap behaviour and the optional ERR flag.
module tb_rf_commit_queue;
  import rf_commit_queue_pkg::*;

  localparam int unsigned NW = NAME_W;
  localparam int unsigned AW = ADDR_W;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  rf_commit_queue_if #(.name_width(NW), .addr_width(AW)) cq ();

  rf_commit_queue #(.name_width(NW), .addr_width(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .cq  (cq)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [NW-1:0] name;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors     = 0;
  int   checks     = 0;
  int   frees_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: a free handshake seen here completes at the next posedge.
  always @(negedge CLK) begin
    if (RST === 1'b0 && cq.FREE_E === 1'b1 && cq.FREE_READY === 1'b1) begin
      frees_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_free: got name %0d expected no free", cq.FREE_NAME);
      end else begin
        mon_e = exp_q.pop_front();
        chk("free_name", 32'(cq.FREE_NAME), 32'(mon_e.name));
        chk("free_addr", 32'(cq.FREE_ADDR), 32'(mon_e.addr));
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST            = 1'b1;
    cq.ENQ_E       = 1'b0;
    cq.ENQ_NAME    = '0;
    cq.ENQ_ADDR    = '0;
    cq.DONE_E_1    = 1'b0;
    cq.DONE_NAME_1 = '0;
    cq.DONE_E_2    = 1'b0;
    cq.DONE_NAME_2 = '0;
    cq.FREE_READY  = 1'b0;
    tick();
    tick();
    exp_q.delete();
    RST = 1'b0;
  endtask

  task automatic enq(input int name, input int addr);
    cq.ENQ_E    = 1'b1;
    cq.ENQ_NAME = NW'(name);
    cq.ENQ_ADDR = AW'(addr);
    exp_q.push_back({NW'(name), AW'(addr)});
    tick();
    cq.ENQ_E = 1'b0;
  endtask

  task automatic done2(input bit e1, input int n1, input bit e2, input int n2);
    cq.DONE_E_1    = e1;
    cq.DONE_NAME_1 = NW'(n1);
    cq.DONE_E_2    = e2;
    cq.DONE_NAME_2 = NW'(n2);
    tick();
    cq.DONE_E_1 = 1'b0;
    cq.DONE_E_2 = 1'b0;
  endtask

  initial begin
    do_reset();

    // Reset state.
    chk("rst_count", 32'(cq.COUNT), 0);
    chk("rst_enq_ready", 32'(cq.ENQ_READY), 1);
    chk("rst_free_e", 32'(cq.FREE_E), 0);
    chk("rst_free_name", 32'(cq.FREE_NAME), 0);
    chk("rst_free_addr", 32'(cq.FREE_ADDR), 0);
    chk("rst_err", 32'(cq.ERR), 0);

    // Basic: enqueue 0,1,2; done 0 -> free next cycle; pop.
    enq(0, 5); enq(1, 6); enq(2, 7);
    chk("t1_count3", 32'(cq.COUNT), 3);
    chk("t1_free_e_pre", 32'(cq.FREE_E), 0);
    done2(1'b1, 0, 1'b0, 0);
    chk("t1_free_e", 32'(cq.FREE_E), 1);
    chk("t1_free_name", 32'(cq.FREE_NAME), 0);
    chk("t1_free_addr", 32'(cq.FREE_ADDR), 5);
    cq.FREE_READY = 1'b1;
    tick();
    cq.FREE_READY = 1'b0;
    chk("t1_count2", 32'(cq.COUNT), 2);
    chk("t1_free_e_post", 32'(cq.FREE_E), 0);

    // Reset mid-operation discards entries.
    do_reset();
    chk("t1_rst_count", 32'(cq.COUNT), 0);
    chk("t1_rst_free_e", 32'(cq.FREE_E), 0);

    // Younger done waits behind incomplete head.
    enq(0, 10); enq(1, 11);
    done2(1'b1, 1, 1'b0, 0);
    cq.FREE_READY = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t2_head_blocked", 32'(cq.FREE_E), 0);
      tick();
    end
    done2(1'b1, 0, 1'b0, 0);
    chk("t2_free0_e", 32'(cq.FREE_E), 1);
    chk("t2_free0_name", 32'(cq.FREE_NAME), 0);
    tick();
    chk("t2_free1_e", 32'(cq.FREE_E), 1);
    chk("t2_free1_name", 32'(cq.FREE_NAME), 1);
    tick();
    cq.FREE_READY = 1'b0;
    chk("t2_free_e_end", 32'(cq.FREE_E), 0);
    chk("t2_count_end", 32'(cq.COUNT), 0);

    // Full, pop with enqueue held, then wrap to name 0.
    do_reset();
    enq(0, 20); enq(1, 21); enq(2, 22); enq(3, 23);
    chk("t3_full_count", 32'(cq.COUNT), 4);
    chk("t3_full_ready", 32'(cq.ENQ_READY), 0);
    done2(1'b1, 0, 1'b0, 0);
    chk("t3_free_e", 32'(cq.FREE_E), 1);
    cq.ENQ_E      = 1'b1;
    cq.ENQ_NAME   = '0;
    cq.ENQ_ADDR   = AW'(24);
    cq.FREE_READY = 1'b1;
    tick();
    cq.FREE_READY = 1'b0;
    chk("t3_pop_count", 32'(cq.COUNT), 3);
    chk("t3_ready_after_pop", 32'(cq.ENQ_READY), 1);
    exp_q.push_back({NW'(0), AW'(24)});
    tick();
    cq.ENQ_E = 1'b0;
    chk("t3_wrap_count", 32'(cq.COUNT), 4);
    chk("t3_wrap_ready", 32'(cq.ENQ_READY), 0);
    done2(1'b1, 1, 1'b1, 2);
    done2(1'b1, 3, 1'b1, 0);
    cq.FREE_READY = 1'b1;
    for (int i = 0; i < 20 && cq.COUNT != 0; i++) tick();
    cq.FREE_READY = 1'b0;
    chk("t3_drain_count", 32'(cq.COUNT), 0);

    // Stall: FREE_E held stable while FREE_READY=0, single pop after.
    do_reset();
    enq(0, 9);
    done2(1'b1, 0, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_free_e", 32'(cq.FREE_E), 1);
      chk("t4_stall_name", 32'(cq.FREE_NAME), 0);
      chk("t4_stall_addr", 32'(cq.FREE_ADDR), 9);
      chk("t4_stall_count", 32'(cq.COUNT), 1);
      tick();
    end
    cq.FREE_READY = 1'b1;
    tick();
    cq.FREE_READY = 1'b0;
    chk("t4_pop_count", 32'(cq.COUNT), 0);
    chk("t4_pop_free_e", 32'(cq.FREE_E), 0);

    // Dual-port done with done heads -> four back-to-back frees.
    do_reset();
    enq(0, 30); enq(1, 31); enq(2, 32); enq(3, 33);
    done2(1'b1, 0, 1'b1, 1);
    done2(1'b1, 2, 1'b1, 3);
    cq.FREE_READY = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("t5_burst_free_e", 32'(cq.FREE_E), 1);
      chk("t5_burst_name", 32'(cq.FREE_NAME), 32'(i));
      tick();
    end
    cq.FREE_READY = 1'b0;
    chk("t5_count_end", 32'(cq.COUNT), 0);
    chk("t5_free_e_end", 32'(cq.FREE_E), 0);

    // Done on an unallocated name: ignored functionally; ERR per build.
    do_reset();
    done2(1'b1, 3, 1'b0, 0);
`ifdef COMMIT_QUEUE_CHECK_EN
    chk("t6_err_set", 32'(cq.ERR), 1);
    tick(); tick();
    chk("t6_err_held", 32'(cq.ERR), 1);
`else
    chk("t6_err_tied", 32'(cq.ERR), 0);
`endif
    enq(0, 1); enq(1, 2); enq(2, 3); enq(3, 4);
    done2(1'b1, 0, 1'b0, 0);
    cq.FREE_READY = 1'b1;
    tick();
    cq.FREE_READY = 1'b0;
    chk("t6_slot3_not_done", 32'(cq.FREE_E), 0);
    chk("t6_count", 32'(cq.COUNT), 3);
    do_reset();
    chk("t6_rst_err", 32'(cq.ERR), 0);
    chk("t6_rst_count", 32'(cq.COUNT), 0);

    tick();
    chk("sb_drained", 32'(exp_q.size()), 0);
    chk("sb_frees_seen", 32'(frees_seen), 14);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
